ysyx_22041461_wbu: RTL and testbench
====================================

YSYX_22041461_WBU -- requirements
Module: ysyx_22041461_WBU

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  execute stage offers a result.
REQ-005 in_ready  out  1  WBU accepts offered result this cycle.
REQ-006 in_rd  in  5  destination GPR index.
REQ-007 in_sel  in  4  source select: 0 none, 1 dest, 2 pc, 3 snpc, 4 imm, 5 mem, 6 const 0, 7 const 1, 8 csr_data; 9-15 none.
REQ-008 in_dest, in_pc, in_snpc, in_imm, in_csr  in  64 each  candidate write-back values.
REQ-009 mem_rvalid  in  1  load data returned; mem_rdata  in  64  load data.
REQ-010 reg_wen  out  1  GPR write strobe; reg_rd  out  5; reg_wdata  out  64.
REQ-011 retire  out  1  one-cycle instruction-complete pulse; retire_pc  out  64.
REQ-012 pend_mask  out  32  GPRs with an outstanding load write.
REQ-013 inst_cnt  out  64  retired-instruction count.
REQ-014 err_spur, err_tmo  out  1 each  sticky spurious-response and load-timeout flags.

Function
REQ-015 States SHALL be IDLE and WAIT_MEM; in_ready SHALL be 1 exactly in IDLE.
REQ-016 Accept = in_valid & in_ready; the value for in_sel SHALL be selected and in_rd, in_pc latched at accept.
REQ-017 Accept with in_sel != 5: next cycle reg_wen=1 (if in_rd != 0 and in_sel in 1..8), reg_rd=in_rd, reg_wdata=selected value, retire=1, retire_pc=in_pc; state stays IDLE (1-cycle latency, back-to-back accepts allowed).
REQ-018 Accept with in_sel == 5: state -> WAIT_MEM, wait counter cleared; no write or retire that cycle's successor.
REQ-019 In WAIT_MEM with mem_rvalid=1: next cycle reg_wen=(rd!=0), reg_wdata=mem_rdata, reg_rd=latched rd, retire=1; state -> IDLE.
REQ-020 In WAIT_MEM without mem_rvalid, 8-bit wait counter SHALL increment; when it reaches 255 state -> IDLE, err_tmo set, no write, retire=1.
REQ-021 mem_rvalid=1 while in IDLE (including the cycle a load is accepted) SHALL set err_spur and SHALL be otherwise ignored.
REQ-022 pend_mask SHALL be one-hot of latched rd while in WAIT_MEM and rd != 0, else 0.
REQ-023 reg_wen, retire SHALL be single-cycle pulses; reg_rd/reg_wdata/retire_pc hold last value when not pulsing.
REQ-024 in_rd == 0 or in_sel in {0,9..15}: no reg_wen, retire still pulses.
REQ-025 inst_cnt SHALL increment by 1 on each retire pulse, wrapping 2^64-1 -> 0.
REQ-026 err_spur, err_tmo SHALL stay set until reset.

Reset
REQ-027 rst=1 SHALL force state IDLE, counter 0, reg_wen 0, reg_rd 0, reg_wdata 0, retire 0, retire_pc 0, pend_mask 0, inst_cnt 0, err_spur 0, err_tmo 0.
REQ-028 rst during WAIT_MEM SHALL abandon the load: no write, no retire, in_ready=1 in the cycle after reset deasserts.
REQ-029 Inputs SHALL be ignored while rst=1.

Verification
REQ-030 Accept sel=1 rd=5 dest=0xDEAD -> next cycle reg_wen=1 reg_rd=5 reg_wdata=0xDEAD retire=1, inst_cnt=1.
REQ-031 Three back-to-back accepts sel=3,4,8 rd=1,2,3 -> three consecutive write pulses with snpc, imm, csr values, inst_cnt=3.
REQ-032 Accept sel=5 rd=10, mem_rvalid after 4 cycles with 0x1234 -> in_ready=0 and pend_mask=0x400 for 5 cycles, then write rd=10 0x1234, pend_mask=0.
REQ-033 Accept sel=5 rd=7, no response -> after 255 wait cycles err_tmo=1, no reg_wen, retire=1, in_ready=1.
REQ-034 Accept sel=1 rd=0, and sel=12 rd=4 -> retire pulses, reg_wen never 1; mem_rvalid in IDLE -> err_spur=1.
REQ-035 rst asserted in WAIT_MEM, mem_rvalid next cycle -> no write, no retire, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_22041461_wbu.sv
// Write-back unit: picks the result source, writes the GPR file and retires
// the instruction; loads park in WAIT_MEM until data returns or times out.
module ysyx_22041461_wbu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [3:0]  in_sel,
   input  logic [63:0] in_dest,
   input  logic [63:0] in_pc,
   input  logic [63:0] in_snpc,
   input  logic [63:0] in_imm,
   input  logic [63:0] in_csr,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        reg_wen,
   output logic [4:0]  reg_rd,
   output logic [63:0] reg_wdata,
   output logic        retire,
   output logic [63:0] retire_pc,
   output logic [31:0] pend_mask,
   output logic [63:0] inst_cnt,
   output logic        err_spur,
   output logic        err_tmo
);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t      state, state_nxt;
   logic [7:0]  wcnt, wcnt_nxt;
   logic [4:0]  lat_rd, lrd_nxt;
   logic [63:0] lat_pc, lpc_nxt;
   logic        wen_nxt, ret_nxt, tmo_nxt, spur_nxt;
   logic [4:0]  rd_nxt;
   logic [63:0] wdata_nxt, rpc_nxt;
   logic [63:0] sel_val;
   logic        sel_ok;
   logic        accept;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;

   always_comb begin
      sel_val = '0;
      case (in_sel)
         4'd1:    sel_val = in_dest;
         4'd2:    sel_val = in_pc;
         4'd3:    sel_val = in_snpc;
         4'd4:    sel_val = in_imm;
         4'd7:    sel_val = 64'd1;
         4'd8:    sel_val = in_csr;
         default: sel_val = '0;
      endcase
   end

   assign sel_ok = (in_sel >= 4'd1) && (in_sel <= 4'd8);

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      lrd_nxt   = lat_rd;
      lpc_nxt   = lat_pc;
      wen_nxt   = 1'b0;
      ret_nxt   = 1'b0;
      rd_nxt    = reg_rd;
      wdata_nxt = reg_wdata;
      rpc_nxt   = retire_pc;
      tmo_nxt   = err_tmo;
      spur_nxt  = err_spur;
      unique case (state)
         IDLE: begin
            spur_nxt = err_spur | mem_rvalid;
            if (accept) begin
               lrd_nxt = in_rd;
               lpc_nxt = in_pc;
               if (in_sel == 4'd5) begin
                  state_nxt = WAIT_MEM;
                  wcnt_nxt  = '0;
               end else begin
                  wen_nxt = sel_ok && (in_rd != 5'd0);
                  ret_nxt = 1'b1;
                  rpc_nxt = in_pc;
                  if (wen_nxt) begin
                     rd_nxt    = in_rd;
                     wdata_nxt = sel_val;
                  end
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               state_nxt = IDLE;
               wen_nxt   = (lat_rd != 5'd0);
               ret_nxt   = 1'b1;
               rpc_nxt   = lat_pc;
               if (wen_nxt) begin
                  rd_nxt    = lat_rd;
                  wdata_nxt = mem_rdata;
               end
            end else begin
               wcnt_nxt = wcnt + 8'd1;
               // the 255th silent wait cycle gives up on the load
               if (wcnt == 8'hfe) begin
                  state_nxt = IDLE;
                  tmo_nxt   = 1'b1;
                  ret_nxt   = 1'b1;
                  rpc_nxt   = lat_pc;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= '0;
         lat_rd    <= '0;
         lat_pc    <= '0;
         reg_wen   <= 1'b0;
         reg_rd    <= '0;
         reg_wdata <= '0;
         retire    <= 1'b0;
         retire_pc <= '0;
         inst_cnt  <= '0;
         err_spur  <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wcnt      <= wcnt_nxt;
         lat_rd    <= lrd_nxt;
         lat_pc    <= lpc_nxt;
         reg_wen   <= wen_nxt;
         reg_rd    <= rd_nxt;
         reg_wdata <= wdata_nxt;
         retire    <= ret_nxt;
         retire_pc <= rpc_nxt;
         inst_cnt  <= inst_cnt + {63'd0, ret_nxt};
         err_spur  <= spur_nxt;
         err_tmo   <= tmo_nxt;
      end
   end

   assign pend_mask = (state == WAIT_MEM && lat_rd != 5'd0)
                    ? (32'd1 << lat_rd) : 32'd0;

endmodule

// File: tb/tb_ysyx_22041461_wbu.sv
// Directed bench for the write-back unit: ALU results, loads, timeout,
// spurious responses and reset during an outstanding load.
module tb_ysyx_22041461_wbu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [3:0]  in_sel;
   logic [63:0] in_dest, in_pc, in_snpc, in_imm, in_csr;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        reg_wen;
   logic [4:0]  reg_rd;
   logic [63:0] reg_wdata;
   logic        retire;
   logic [63:0] retire_pc;
   logic [31:0] pend_mask;
   logic [63:0] inst_cnt;
   logic        err_spur, err_tmo;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ysyx_22041461_wbu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_sel(in_sel),
      .in_dest(in_dest), .in_pc(in_pc), .in_snpc(in_snpc),
      .in_imm(in_imm), .in_csr(in_csr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .reg_wen(reg_wen), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
      .retire(retire), .retire_pc(retire_pc),
      .pend_mask(pend_mask), .inst_cnt(inst_cnt),
      .err_spur(err_spur), .err_tmo(err_tmo)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [3:0] s, input logic [4:0] rd,
                        input logic [63:0] pc);
      in_valid = 1'b1;
      in_sel   = s;
      in_rd    = rd;
      in_pc    = pc;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wen"}, 64'(reg_wen), 0);
      chk({tag, "_ret"}, 64'(retire), 0);
      chk({tag, "_rd"}, 64'(reg_rd), 0);
      chk({tag, "_wdata"}, reg_wdata, 0);
      chk({tag, "_rpc"}, retire_pc, 0);
      chk({tag, "_cnt"}, inst_cnt, 0);
      chk({tag, "_pend"}, 64'(pend_mask), 0);
      chk({tag, "_spur"}, 64'(err_spur), 0);
      chk({tag, "_tmo"}, 64'(err_tmo), 0);
      chk({tag, "_rdy"}, 64'(in_ready), 1);
   endtask

   initial begin
      int early;
      rst = 1'b1;
      in_valid = 1'b0; in_rd = '0; in_sel = '0;
      in_dest = 64'hdead; in_pc = '0; in_snpc = 64'h1004;
      in_imm = 64'h77; in_csr = 64'hc5c;
      mem_rvalid = 1'b0; mem_rdata = '0;
      tick(); tick();
      chk_reset("rst");
      rst = 1'b0;

      // single ALU result
      offer(4'd1, 5'd5, 64'h1000);
      tick();
      in_valid = 1'b0;
      chk("w1_wen", 64'(reg_wen), 1);
      chk("w1_rd", 64'(reg_rd), 5);
      chk("w1_wdata", reg_wdata, 64'hdead);
      chk("w1_ret", 64'(retire), 1);
      chk("w1_rpc", retire_pc, 64'h1000);
      chk("w1_cnt", inst_cnt, 1);
      tick();
      chk("w1_wen_drop", 64'(reg_wen), 0);
      chk("w1_ret_drop", 64'(retire), 0);
      chk("w1_hold", reg_wdata, 64'hdead);

      // back-to-back snpc, imm, csr
      offer(4'd3, 5'd1, 64'h2000);
      tick();
      chk("b2b0_wen", 64'(reg_wen), 1);
      chk("b2b0", {reg_rd, reg_wdata[58:0]}, {5'd1, 59'h1004});
      offer(4'd4, 5'd2, 64'h2004);
      tick();
      chk("b2b1_wen", 64'(reg_wen), 1);
      chk("b2b1", {reg_rd, reg_wdata[58:0]}, {5'd2, 59'h77});
      offer(4'd8, 5'd3, 64'h2008);
      tick();
      chk("b2b2_wen", 64'(reg_wen), 1);
      chk("b2b2", {reg_rd, reg_wdata[58:0]}, {5'd3, 59'hc5c});
      chk("b2b_cnt", inst_cnt, 4);
      chk("b2b_rpc", retire_pc, 64'h2008);

      // pc and constant sources
      offer(4'd2, 5'd9, 64'h3000);
      tick();
      chk("sel_pc", reg_wdata, 64'h3000);
      offer(4'd7, 5'd9, 64'h3004);
      tick();
      chk("sel_one", reg_wdata, 1);
      offer(4'd6, 5'd9, 64'h3008);
      tick();
      chk("sel_zero", reg_wdata, 0);
      chk("sel_cnt", inst_cnt, 7);

      // load answered on the fifth wait cycle
      offer(4'd5, 5'd10, 64'h4000);
      tick();
      in_valid = 1'b0;
      chk("ld_nowen", 64'(reg_wen), 0);
      chk("ld_noret", 64'(retire), 0);
      for (int i = 0; i < 4; i++) begin
         chk("ld_rdy", 64'(in_ready), 0);
         chk("ld_pend", 64'(pend_mask), 64'h400);
         tick();
      end
      chk("ld_rdy5", 64'(in_ready), 0);
      chk("ld_pend5", 64'(pend_mask), 64'h400);
      chk("ld_wen_wait", 64'(reg_wen), 0);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h1234;
      tick();
      mem_rvalid = 1'b0;
      chk("ld_wen", 64'(reg_wen), 1);
      chk("ld_rd", 64'(reg_rd), 10);
      chk("ld_wdata", reg_wdata, 64'h1234);
      chk("ld_ret", 64'(retire), 1);
      chk("ld_rpc", retire_pc, 64'h4000);
      chk("ld_pend_clr", 64'(pend_mask), 0);
      chk("ld_rdy_back", 64'(in_ready), 1);
      chk("ld_cnt", inst_cnt, 8);
      chk("ld_nospur", 64'(err_spur), 0);

      // load that never returns
      offer(4'd5, 5'd7, 64'h5000);
      tick();
      in_valid = 1'b0;
      chk("tmo_pend", 64'(pend_mask), 64'h80);
      early = 0;
      for (int i = 0; i < 254; i++) begin
         tick();
         if (retire || in_ready || reg_wen || err_tmo) early++;
      end
      chk("tmo_early", 64'(early), 0);
      tick();
      chk("tmo_flag", 64'(err_tmo), 1);
      chk("tmo_wen", 64'(reg_wen), 0);
      chk("tmo_ret", 64'(retire), 1);
      chk("tmo_rdy", 64'(in_ready), 1);
      chk("tmo_rpc", retire_pc, 64'h5000);
      chk("tmo_cnt", inst_cnt, 9);
      chk("tmo_hold", reg_wdata, 64'h1234);

      // rd=0 and invalid select retire without writing
      offer(4'd1, 5'd0, 64'h6000);
      tick();
      chk("rd0_ret", 64'(retire), 1);
      chk("rd0_wen", 64'(reg_wen), 0);
      offer(4'd12, 5'd4, 64'h6004);
      tick();
      in_valid = 1'b0;
      chk("sel12_ret", 64'(retire), 1);
      chk("sel12_wen", 64'(reg_wen), 0);
      chk("sel12_cnt", inst_cnt, 11);

      // response with no load outstanding
      chk("spur_pre", 64'(err_spur), 0);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hbeef;
      tick();
      mem_rvalid = 1'b0;
      chk("spur_set", 64'(err_spur), 1);
      chk("spur_wen", 64'(reg_wen), 0);
      chk("spur_ret", 64'(retire), 0);
      tick();
      chk("spur_sticky", 64'(err_spur), 1);
      chk("tmo_sticky", 64'(err_tmo), 1);

      // reset abandons an outstanding load
      offer(4'd5, 5'd3, 64'h7000);
      tick();
      in_valid = 1'b0;
      chk("rl_pend", 64'(pend_mask), 64'h8);
      rst = 1'b1;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hffff;
      offer(4'd1, 5'd3, 64'h7004);
      tick();
      rst = 1'b0;
      mem_rvalid = 1'b0;
      in_valid = 1'b0;
      chk_reset("rl");
      tick();
      chk("rl_ret_after", 64'(retire), 0);
      chk("rl_cnt_after", inst_cnt, 0);
      chk("rl_spur_after", 64'(err_spur), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
